// File: rtl/continuous_bus_buffer.sv
// Lossy in-order bus buffer: DEPTH-entry circular store feeding a registered valid/ready output.
// Loss statistics (drop_cnt, hwm) exist only when CONTINUOUS_BUS_BUFFER_STATS_EN is defined.
module continuous_bus_buffer #(
   parameter int BUS_WIDTH = 32,
   parameter int DEPTH     = 4,
   parameter int OVERWRITE = 0,
   parameter int CNT_W     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     up_valid,
   input  logic [BUS_WIDTH-1:0]     up_bus,
   output logic                     dn_valid,
   input  logic                     dn_ready,
   output logic [BUS_WIDTH-1:0]     dn_bus,
   output logic [CNT_W-1:0]         drop_cnt,
   output logic [$clog2(DEPTH):0]   hwm,
   input  logic                     stats_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [BUS_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]        r_wr_ptr;
   logic [PW-1:0]        r_rd_ptr;
   logic                 r_dn_valid;
   logic [BUS_WIDTH-1:0] r_dn_bus;

   logic [PW-1:0] w_count;
   logic [PW-1:0] w_count_nxt;
   logic          w_full;
   logic          w_empty;
   logic          w_free;
   logic          w_load;
   logic          w_drop;
   logic          w_wr;
   logic          w_ovr_pop;

   assign w_count   = r_wr_ptr - r_rd_ptr;
   assign w_full    = (w_count == PW'(DEPTH));
   assign w_empty   = (w_count == '0);
   assign w_free    = !r_dn_valid || dn_ready;
   assign w_load    = w_free && !w_empty;
   // A same-cycle load frees a slot, so a full store only loses data when nothing is loaded.
   assign w_drop    = up_valid && w_full && !w_load;
   assign w_ovr_pop = w_drop && (OVERWRITE != 0);
   assign w_wr      = up_valid && (!w_drop || (OVERWRITE != 0));
   assign w_count_nxt = w_count + PW'(w_wr) - PW'(w_load) - PW'(w_ovr_pop);

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr[AW-1:0]] <= up_bus;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_dn_valid <= 1'b0;
         r_dn_bus   <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         r_rd_ptr <= r_rd_ptr + PW'(w_load) + PW'(w_ovr_pop);
         if (w_free) begin
            r_dn_valid <= w_load;
            if (w_load) begin
               r_dn_bus <= r_mem[r_rd_ptr[AW-1:0]];
            end
         end
      end
   end

   assign dn_valid = r_dn_valid;
   assign dn_bus   = r_dn_bus;

`ifdef CONTINUOUS_BUS_BUFFER_STATS_EN
   logic [CNT_W-1:0] r_drop_cnt;
   logic [PW-1:0]    r_hwm;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_drop_cnt <= '0;
         r_hwm      <= '0;
      end else if (stats_clr) begin
         r_drop_cnt <= CNT_W'(w_drop);
         r_hwm      <= w_count_nxt;
      end else begin
         if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
         end
         if (w_count_nxt > r_hwm) begin
            r_hwm <= w_count_nxt;
         end
      end
   end

   assign drop_cnt = r_drop_cnt;
   assign hwm      = r_hwm;
`else
   logic w_unused_stats;
   assign w_unused_stats = stats_clr ^ (|w_count_nxt);
   assign drop_cnt = '0;
   assign hwm      = '0;
`endif

endmodule
